// File: rtl/ece385_pio_pkg.sv
// Shared register map and constants for the multi-channel Avalon-MM output PIO.
package ece385_pio_pkg;

   localparam logic [2:0] REG_DATA       = 3'd0;
   localparam logic [2:0] REG_BLINK_MASK = 3'd1;
   localparam logic [2:0] REG_BLINK_DIV  = 3'd2;
   localparam logic [2:0] REG_STATUS     = 3'd3;
   localparam logic [2:0] REG_SET        = 3'd4;
   localparam logic [2:0] REG_CLR        = 3'd5;
   localparam logic [2:0] REG_TGL        = 3'd6;
   localparam logic [2:0] REG_PULSE      = 3'd7;

   localparam int PRESC_W = 24;

endpackage

// File: rtl/ece385_pio_chan.sv
// One PIO output channel: data register, timed self-clearing pulse mask and
// the DATA/SET/CLR/TGL/PULSE write operations.
module ece385_pio_chan
   import ece385_pio_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0,
   parameter int               PULSE_CYCLES = 16
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr,
   input  logic [2:0]       reg_sel,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] data
);

   localparam int CNT_W = $clog2(PULSE_CYCLES + 1);

   logic [WIDTH-1:0] pulse_mask;
   logic [CNT_W-1:0] pulse_cnt;
   logic             expire;
   logic [WIDTH-1:0] data_base, mask_base, data_nxt, mask_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   // Expiry is resolved first so that a host op in the same cycle lands on the
   // already-cleared value and a PULSE write re-arms cleanly.
   always_comb begin
      expire    = (pulse_cnt == CNT_W'(1));
      data_base = expire ? (data & ~pulse_mask) : data;
      mask_base = expire ? '0 : pulse_mask;
      data_nxt  = data_base;
      mask_nxt  = mask_base;
      cnt_nxt   = (pulse_cnt != '0) ? pulse_cnt - CNT_W'(1) : '0;
      if (wr) begin
         case (reg_sel)
            REG_DATA: begin
               data_nxt = wd;
               mask_nxt = '0;
               cnt_nxt  = '0;
            end
            REG_SET: data_nxt = data_base | wd;
            REG_CLR: begin
               data_nxt = data_base & ~wd;
               mask_nxt = mask_base & ~wd;
            end
            REG_TGL: data_nxt = data_base ^ wd;
            REG_PULSE: begin
               data_nxt = data_base | wd;
               mask_nxt = mask_base | wd;
               cnt_nxt  = CNT_W'(PULSE_CYCLES);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data       <= RESET_VAL;
         pulse_mask <= '0;
         pulse_cnt  <= '0;
      end else begin
         data       <= data_nxt;
         pulse_mask <= mask_nxt;
         pulse_cnt  <= cnt_nxt;
      end
   end

endmodule

// File: rtl/ece385_pio_out_multi.sv
// Parametrised Avalon-MM output PIO with NUM_CH channels, timed pulses and
// optional hardware blink (enabled by defining ECE385_PIO_BLINK_EN).
module ece385_pio_out_multi
   import ece385_pio_pkg::*;
#(
   parameter int               NUM_CH       = 4,
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0,
   parameter int               PULSE_CYCLES = 16,
   parameter int               ADDR_W       = $clog2(NUM_CH) + 3
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDR_W-1:0]       address,
   input  logic                    chipselect,
   input  logic                    write_n,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   output logic [NUM_CH*WIDTH-1:0] out_port
);

   localparam int CH_W = (ADDR_W > 3) ? ADDR_W - 3 : 1;

   logic                    wr;
   logic [2:0]              reg_sel;
   logic [CH_W-1:0]         chan;
   logic [WIDTH-1:0]        wd;
   logic [NUM_CH-1:0]       wr_ch;
   logic [NUM_CH*WIDTH-1:0] data_all;
   logic                    unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign reg_sel      = address[2:0];
   assign wd           = writedata[WIDTH-1:0];
   assign unused_wdata = &{1'b0, writedata};

   if (ADDR_W > 3) begin : g_chan_addr
      assign chan = address[ADDR_W-1:3];
   end else begin : g_chan_single
      assign chan = 1'b0;
   end

   // Channel indices >= NUM_CH never match, so such writes are dropped here.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign wr_ch[c] = wr && (chan == CH_W'(c));

      ece385_pio_chan #(
         .WIDTH        (WIDTH),
         .RESET_VAL    (RESET_VAL),
         .PULSE_CYCLES (PULSE_CYCLES)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .wr      (wr_ch[c]),
         .reg_sel (reg_sel),
         .wd      (wd),
         .data    (data_all[c*WIDTH +: WIDTH])
      );
   end

`ifdef ECE385_PIO_BLINK_EN
   logic [NUM_CH*WIDTH-1:0]   blink_mask;
   logic [NUM_CH*PRESC_W-1:0] blink_div;
   logic [PRESC_W-1:0]        presc;
   logic                      phase;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_mask <= '0;
         blink_div  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_ch[c] && reg_sel == REG_BLINK_MASK)
               blink_mask[c*WIDTH +: WIDTH] <= wd;
            if (wr_ch[c] && reg_sel == REG_BLINK_DIV)
               blink_div[c*PRESC_W +: PRESC_W] <= writedata[PRESC_W-1:0];
         end
      end
   end

   // Shared blink timebase, paced by channel 0's divider.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc <= '0;
         phase <= 1'b0;
      end else if (wr_ch[0] && reg_sel == REG_BLINK_DIV) begin
         presc <= '0;
      end else if (blink_div[PRESC_W-1:0] == '0) begin
         presc <= '0;
         phase <= 1'b0;
      end else if (presc == blink_div[PRESC_W-1:0]) begin
         presc <= '0;
         phase <= ~phase;
      end else begin
         presc <= presc + PRESC_W'(1);
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_out
      assign out_port[c*WIDTH +: WIDTH] = data_all[c*WIDTH +: WIDTH]
                                        ^ (blink_mask[c*WIDTH +: WIDTH] & {WIDTH{phase}});
   end
`else
   assign out_port = data_all;
`endif

   always_comb begin
      readdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (chipselect && chan == CH_W'(c)) begin
            case (reg_sel)
               REG_DATA:       readdata = 32'(data_all[c*WIDTH +: WIDTH]);
               REG_STATUS:     readdata = 32'(out_port[c*WIDTH +: WIDTH]);
`ifdef ECE385_PIO_BLINK_EN
               REG_BLINK_MASK: readdata = 32'(blink_mask[c*WIDTH +: WIDTH]);
               REG_BLINK_DIV:  readdata = 32'(blink_div[c*PRESC_W +: PRESC_W]);
`endif
               default:        readdata = '0;
            endcase
         end
      end
   end

endmodule
